// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider and its neighbours in the ALU.
// Holds the FSM state encoding and the default operand width.
// The same width constant is used by the multiplier and the ALU top.
package div_pkg;

  // Default operand width for the 3-bit ALU datapath
  localparam int DIV_WIDTH = 3;

  // State encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_CALC = S_CALC,
    ST_DONE = S_DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract B, restore or keep.
// Purely combinational, zero latency.
// No flow control; the caller decides when to register the result.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH+1:0] w_a_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_nonneg;

  // The shifted partial remainder is one bit wider than A so the compare sees every
  // bit; in practice A < B always holds, so the top bit is zero and W+1 bits suffice
  // for the trial difference.
  always_comb begin
    w_a_sh   = {i_a, i_q[WIDTH-1]};
    w_nonneg = (w_a_sh >= {2'b00, i_b});
    w_trial  = w_a_sh[WIDTH:0] - {1'b0, i_b};
    o_a      = w_nonneg ? w_trial : w_a_sh[WIDTH:0];
    o_q      = {i_q[WIDTH-2:0], w_nonneg};
  end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider for the ALU division slot (init/done handshake).
// Latency: done rises on the WIDTH-th edge after the edge that samples init in IDLE.
// No backpressure; done holds while init stays high, block returns to IDLE when it drops.
// Optional macro DIV_SEQ_DIV0_FLAG_EN adds a registered divide-by-zero flag output dz.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [WIDTH-1:0] DV,
  input  logic [WIDTH-1:0] DR,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] R,
  output logic             done
`ifdef DIV_SEQ_DIV0_FLAG_EN
  ,
  output logic             dz
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic             w_start;
  logic             w_finish;

  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_r;

  logic [WIDTH:0]   w_a_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_a (r_a),
    .i_q (r_q),
    .i_b (r_b),
    .o_a (w_a_nxt),
    .o_q (w_q_nxt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and control strobes; start only from IDLE so a held init cannot restart
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (init) begin
          w_start     = 1'b1;
          w_state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        if (r_cnt == CNT_W'(1)) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!init) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: load operands on start, iterate in CALC, latch results on the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_q   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_c   <= '0;
      r_r   <= '0;
    end else if (w_start) begin
      r_a   <= '0;
      r_q   <= DV;
      r_b   <= DR;
      r_cnt <= CNT_W'(WIDTH);
    end else if (r_state == ST_CALC) begin
      r_a   <= w_a_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_finish) begin
        r_c <= w_q_nxt;
        r_r <= w_a_nxt[WIDTH-1:0];
      end
    end
  end

`ifdef DIV_SEQ_DIV0_FLAG_EN
  logic r_dz;

  // Divide-by-zero flag: set on entry to DONE, cleared on the next start
  always_ff @(posedge clk) begin
    if (rst)           r_dz <= 1'b0;
    else if (w_start)  r_dz <= 1'b0;
    else if (w_finish) r_dz <= (r_b == '0);
  end

  assign dz = r_dz;
`endif

  assign C    = r_c;
  assign R    = r_r;
  assign done = (r_state == ST_DONE);

endmodule
